// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_pkg
// Description : Shared constants for the multi-cycle MIPS control FSM.
//               Contents: FSM state encoding, the INST_* decoded instruction
//               codes, PC source, register destination and writeback
//               selects, and small instruction classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    STATE_FETCH  = 3'd0,
    STATE_DECODE = 3'd1,
    STATE_EXEC   = 3'd2,
    STATE_MEM    = 3'd3,
    STATE_WB     = 3'd4,
    STATE_HALT   = 3'd5
  } state_e;

  // Decoded instruction codes. Every code not listed here is treated as
  // unknown and retires like a NOP.
  localparam logic [5:0] INST_NOP   = 6'd0;
  localparam logic [5:0] INST_ADDU  = 6'd1;
  localparam logic [5:0] INST_SUBU  = 6'd2;
  localparam logic [5:0] INST_SLT   = 6'd3;
  localparam logic [5:0] INST_ORI   = 6'd4;
  localparam logic [5:0] INST_LUI   = 6'd5;
  localparam logic [5:0] INST_ADDI  = 6'd6;
  localparam logic [5:0] INST_ADDIU = 6'd7;
  localparam logic [5:0] INST_LW    = 6'd8;
  localparam logic [5:0] INST_LB    = 6'd9;
  localparam logic [5:0] INST_SW    = 6'd10;
  localparam logic [5:0] INST_SB    = 6'd11;
  localparam logic [5:0] INST_BEQ   = 6'd12;
  localparam logic [5:0] INST_J     = 6'd13;
  localparam logic [5:0] INST_JAL   = 6'd14;
  localparam logic [5:0] INST_JR    = 6'd15;
  localparam logic [5:0] INST_JALR  = 6'd16;
  localparam logic [5:0] INST_HLT   = 6'd17;

  localparam logic [1:0] PCSRC_PC4    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_PC4 = 2'd2;

  function automatic logic inst_is_load(input logic [5:0] inst);
    return (inst == INST_LW) || (inst == INST_LB);
  endfunction

  function automatic logic inst_is_store(input logic [5:0] inst);
    return (inst == INST_SW) || (inst == INST_SB);
  endfunction

  function automatic logic inst_is_byte(input logic [5:0] inst);
    return (inst == INST_LB) || (inst == INST_SB);
  endfunction

  function automatic logic inst_uses_imm(input logic [5:0] inst);
    return (inst == INST_ORI)  || (inst == INST_LUI)   ||
           (inst == INST_ADDI) || (inst == INST_ADDIU) ||
           inst_is_load(inst)  || inst_is_store(inst);
  endfunction

  // Three-register ALU ops write rd instead of rt.
  function automatic logic inst_writes_rd(input logic [5:0] inst);
    return (inst == INST_ADDU) || (inst == INST_SUBU) || (inst == INST_SLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_memwait.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_memwait
// Description : Memory handshake helper shared by the FETCH and MEM phases.
//               Acknowledges a request when mem_ready arrives and, when
//               MEM_TIMEOUT > 0, flags a timeout on the MEM_TIMEOUT-th
//               consecutive unacknowledged request cycle.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               req            - a request is being driven this cycle
//               mem_ready      - memory acknowledge
//               ack            - request completes this cycle
//               timeout        - request has waited too long this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_memwait #(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic mem_ready,
  output logic ack,
  output logic timeout
);

  // mem_ready outside a request is ignored.
  assign ack = req & mem_ready;

  generate
    if (MEM_TIMEOUT > 0) begin : g_timeout
      localparam int unsigned    CW    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
      localparam logic [CW-1:0]  LIMIT = CW'(MEM_TIMEOUT - 1);

      logic [CW-1:0] wait_cnt_q;
      logic [CW-1:0] wait_cnt_d;
      logic          w_stall;

      assign w_stall = req & ~mem_ready;

      // Counts stalled cycles of the current request; any gap or ack
      // restarts the count so back-to-back requests are timed separately.
      always_comb begin
        wait_cnt_d = '0;
        if (w_stall && (wait_cnt_q != LIMIT)) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wait_cnt_q <= '0;
        end else begin
          wait_cnt_q <= wait_cnt_d;
        end
      end

      assign timeout = w_stall & (wait_cnt_q == LIMIT);
    end else begin : g_no_timeout
      logic w_unused;
      assign w_unused = ^{clk, rst};
      assign timeout  = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle control FSM for the MIPS core. Sequences
//               FETCH/DECODE/EXEC/MEM/WB/HALT from the decoded instruction
//               code and drives PC/IR/regfile strobes, datapath selects and
//               the single-port memory request handshake.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               dec_inst        - decoded instruction code (INST_*)
//               zero, ovf       - ALU flags, sampled in EXEC
//               mem_ready       - memory acknowledge
//               state           - current FSM state (debug)
//               pc_we, pc_src   - PC write strobe and source select
//               ir_we           - IR load strobe
//               mem_req/sel/we/byte - memory request and qualifiers
//               alu_src_imm     - ALU B operand is the immediate
//               reg_we/dst, wb_sel - register writeback control
//               halted, mem_err - halt status, sticky memory timeout
// Options     : MULTICYCLE_CTRL_PERF_EN adds cycle_cnt and inst_cnt outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  dec_inst,
  input  logic        zero,
  input  logic        ovf,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        ir_we,
  output logic        mem_req,
  output logic        mem_sel,
  output logic        mem_we,
  output logic        mem_byte,
  output logic        alu_src_imm,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic        mem_err
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] inst_cnt
`endif
);

  state_e     state_q, state_d;
  logic [5:0] cur_inst_q, cur_inst_d;
  logic       ovf_q, ovf_d;
  logic       mem_err_q, mem_err_d;

  logic       w_mem_phase;
  logic       w_ack;
  logic       w_timeout;

  logic       w_pc_we;
  logic [1:0] w_pc_src;
  logic       w_ir_we;
  logic       w_mem_sel;
  logic       w_mem_we;
  logic       w_mem_byte;
  logic       w_alu_src_imm;
  logic       w_reg_we;
  logic [1:0] w_reg_dst;
  logic [1:0] w_wb_sel;
  logic       w_halted;

  assign w_mem_phase = (state_q == STATE_FETCH) || (state_q == STATE_MEM);

  multicycle_ctrl_memwait #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_memwait (
    .clk       (clk),
    .rst       (rst),
    .req       (w_mem_phase),
    .mem_ready (mem_ready),
    .ack       (w_ack),
    .timeout   (w_timeout)
  );

  always_comb begin
    state_d       = state_q;
    cur_inst_d    = cur_inst_q;
    ovf_d         = ovf_q;
    mem_err_d     = mem_err_q;
    w_pc_we       = 1'b0;
    w_pc_src      = PCSRC_PC4;
    w_ir_we       = 1'b0;
    w_mem_sel     = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_byte    = 1'b0;
    w_alu_src_imm = 1'b0;
    w_reg_we      = 1'b0;
    w_reg_dst     = REGDST_RT;
    w_wb_sel      = WBSEL_ALU;
    w_halted      = 1'b0;

    case (state_q)
      STATE_FETCH: begin
        if (w_ack) begin
          w_ir_we  = 1'b1;
          w_pc_we  = 1'b1;
          w_pc_src = PCSRC_PC4;
          state_d  = STATE_DECODE;
        end else if (w_timeout) begin
          mem_err_d = 1'b1;
          state_d   = STATE_HALT;
        end
      end

      // cur_inst is still loading here, so decode straight from dec_inst.
      STATE_DECODE: begin
        cur_inst_d = dec_inst;
        case (dec_inst)
          INST_J: begin
            w_pc_we  = 1'b1;
            w_pc_src = PCSRC_JUMP;
            state_d  = STATE_FETCH;
          end
          INST_JAL: begin
            w_pc_we   = 1'b1;
            w_pc_src  = PCSRC_JUMP;
            w_reg_we  = 1'b1;
            w_reg_dst = REGDST_RA;
            w_wb_sel  = WBSEL_PC4;
            state_d   = STATE_FETCH;
          end
          INST_JR: begin
            w_pc_we  = 1'b1;
            w_pc_src = PCSRC_RS;
            state_d  = STATE_FETCH;
          end
          INST_JALR: begin
            w_pc_we   = 1'b1;
            w_pc_src  = PCSRC_RS;
            w_reg_we  = 1'b1;
            w_reg_dst = REGDST_RD;
            w_wb_sel  = WBSEL_PC4;
            state_d   = STATE_FETCH;
          end
          INST_HLT: begin
            state_d = STATE_HALT;
          end
          INST_ADDU, INST_SUBU, INST_SLT, INST_ORI, INST_LUI, INST_ADDI,
          INST_ADDIU, INST_LW, INST_LB, INST_SW, INST_SB, INST_BEQ: begin
            state_d = STATE_EXEC;
          end
          default: begin
            // NOP and unknown codes retire without side effects.
            state_d = STATE_FETCH;
          end
        endcase
      end

      STATE_EXEC: begin
        w_alu_src_imm = inst_uses_imm(cur_inst_q);
        // Overflow only matters at WB, one cycle after the flag is valid.
        ovf_d = ovf;
        if (cur_inst_q == INST_BEQ) begin
          if (zero) begin
            w_pc_we  = 1'b1;
            w_pc_src = PCSRC_BRANCH;
          end
          state_d = STATE_FETCH;
        end else if (inst_is_load(cur_inst_q) || inst_is_store(cur_inst_q)) begin
          state_d = STATE_MEM;
        end else begin
          state_d = STATE_WB;
        end
      end

      STATE_MEM: begin
        w_mem_sel  = 1'b1;
        w_mem_we   = inst_is_store(cur_inst_q);
        w_mem_byte = inst_is_byte(cur_inst_q);
        if (w_ack) begin
          state_d = inst_is_store(cur_inst_q) ? STATE_FETCH : STATE_WB;
        end else if (w_timeout) begin
          mem_err_d = 1'b1;
          state_d   = STATE_HALT;
        end
      end

      STATE_WB: begin
        w_reg_we  = ~((cur_inst_q == INST_ADDI) && ovf_q);
        w_reg_dst = inst_writes_rd(cur_inst_q) ? REGDST_RD : REGDST_RT;
        w_wb_sel  = inst_is_load(cur_inst_q) ? WBSEL_MEM : WBSEL_ALU;
        state_d   = STATE_FETCH;
      end

      STATE_HALT: begin
        w_halted = 1'b1;
      end

      default: begin
        state_d = STATE_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= STATE_FETCH;
      cur_inst_q <= INST_NOP;
      ovf_q      <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_inst_q <= cur_inst_d;
      ovf_q      <= ovf_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // The reset state is FETCH, which would otherwise request memory; gating
  // with rst keeps every output quiet (and drops mem_req) while reset is held.
  assign state       = rst ? 3'd0 : state_q;
  assign pc_we       = w_pc_we       & ~rst;
  assign pc_src      = w_pc_src      & {2{~rst}};
  assign ir_we       = w_ir_we       & ~rst;
  assign mem_req     = w_mem_phase   & ~rst;
  assign mem_sel     = w_mem_sel     & ~rst;
  assign mem_we      = w_mem_we      & ~rst;
  assign mem_byte    = w_mem_byte    & ~rst;
  assign alu_src_imm = w_alu_src_imm & ~rst;
  assign reg_we      = w_reg_we      & ~rst;
  assign reg_dst     = w_reg_dst     & {2{~rst}};
  assign wb_sel      = w_wb_sel      & {2{~rst}};
  assign halted      = w_halted      & ~rst;
  assign mem_err     = mem_err_q     & ~rst;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] inst_cnt_q, inst_cnt_d;
  logic        w_retire;

  // An instruction retires whenever a post-fetch state hands back to FETCH
  // or HALT; this covers jumps, branches, stores, writebacks and HLT.
  assign w_retire = ((state_q == STATE_DECODE) || (state_q == STATE_EXEC) ||
                     (state_q == STATE_MEM)    || (state_q == STATE_WB)) &&
                    ((state_d == STATE_FETCH)  || (state_d == STATE_HALT));

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    inst_cnt_d  = inst_cnt_q;
    if (state_q != STATE_HALT) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
    if (w_retire) begin
      inst_cnt_d = inst_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= 32'd0;
      inst_cnt_q  <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign inst_cnt  = inst_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the MIPS core. It sequences fetch, decode, execute, memory and writeback using the 6-bit decoded instruction code from the instruction decoder. It drives PC/IR/regfile write enables, datapath mux selects and the single-port memory request handshake. It sits between the decoder and the datapath; there is one instance per core.

Parameters:
- MEM_TIMEOUT, 0, max cycles to wait for mem_ready before asserting mem_err; 0 = wait forever.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- dec_inst  in  6  decoded instruction code (INST_* encoding), valid while IR is stable.
- zero  in  1  ALU equality flag, valid in EXEC.
- ovf  in  1  ALU signed-overflow flag, valid in EXEC.
- mem_ready  in  1  memory acknowledge for the current mem_req.
- state  out  3  current FSM state (debug).
- pc_we  out  1  PC write strobe.
- pc_src  out  2  0 = pc+4, 1 = branch target, 2 = jump target, 3 = rs.
- ir_we  out  1  IR load strobe.
- mem_req  out  1  memory request, held until mem_ready.
- mem_sel  out  1  0 = instruction fetch address (PC), 1 = data address (ALU result).
- mem_we  out  1  store enable, qualified by mem_req.
- mem_byte  out  1  byte access (LB/SB).
- alu_src_imm  out  1  ALU B operand is the extended immediate.
- reg_we  out  1  regfile write strobe.
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $31.
- wb_sel  out  2  0 = ALU, 1 = memory, 2 = pc+4.
- halted  out  1  core halted.
- mem_err  out  1  sticky memory timeout flag.

Behaviour:
- States: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, HALT = 5. The state register resets asynchronously to FETCH.
- While rst is high, all outputs are 0, including mem_req and halted.
- Outputs are decoded from the registered state and cur_inst, a 6-bit register that loads dec_inst on the DECODE cycle. Outputs are glitch-free with respect to the state.
- FETCH:
  - Drive mem_req = 1, mem_sel = 0 and hold until mem_ready.
  - In the cycle mem_ready = 1, pulse ir_we = 1 and pc_we = 1 with pc_src = 0, then go to DECODE.
  - mem_ready while mem_req = 0 is ignored.
- DECODE:
  - INST_J: pc_we, pc_src = 2, go to FETCH.
  - INST_JAL: additionally reg_we, reg_dst = 2, wb_sel = 2.
  - INST_JR: pc_we, pc_src = 3, go to FETCH.
  - INST_JALR: additionally reg_we, reg_dst = 1, wb_sel = 2.
  - INST_HLT: go to HALT.
  - INST_NOP or any unknown code: go to FETCH with no strobes.
  - All other codes: go to EXEC.
- EXEC:
  - alu_src_imm = 1 for ORI, LUI, ADDI, ADDIU, LW, LB, SW and SB.
  - INST_BEQ: if zero, pc_we with pc_src = 1. Either way go to FETCH.
  - Loads and stores go to MEM. Everything else goes to WB.
- MEM:
  - mem_req = 1, mem_sel = 1; mem_we = 1 for SW/SB; mem_byte = 1 for LB/SB.
  - Hold until mem_ready. Stores then go to FETCH; loads go to WB.
- WB:
  - reg_we = 1.
  - reg_dst = 1 for ADDU, SUBU and SLT; 0 otherwise.
  - wb_sel = 1 for loads; 0 otherwise.
  - INST_ADDI with ovf = 1 (ovf registered at EXEC): reg_we = 0, so there is no architectural write.
  - Go to FETCH.
- HALT: halted = 1, no strobes. The FSM stays in HALT until rst.
- Latencies with zero-wait memory (mem_ready in the same cycle as mem_req):
  - J/JAL/JR/JALR: 2 cycles.
  - BEQ: 3 cycles.
  - R-type, immediate ops and stores: 4 cycles.
  - Loads: 5 cycles.
- Each wait cycle on mem_ready adds one cycle.
- Timeout: if MEM_TIMEOUT > 0 and a request stays unacknowledged for MEM_TIMEOUT cycles, set mem_err (sticky until rst), drop mem_req and go to HALT.
- Reset mid-transaction (asserted during any state) aborts immediately: mem_req drops asynchronously, and the FSM restarts in FETCH after release.

Optional Feature:
- MULTICYCLE_CTRL_PERF_EN: adds outputs cycle_cnt[31:0] and inst_cnt[31:0].
  - cycle_cnt increments every non-reset, non-HALT cycle.
  - inst_cnt increments on every exit to FETCH or HALT from DECODE, EXEC, MEM or WB.
  - Both counters wrap modulo 2^32, reset to 0 and freeze in HALT.
- Without the macro, neither the ports nor the counters exist.

Decomposition:
- The shared defines.v holds the INST_* codes and the new STATE_*, PCSRC_*, REGDST_* and WBSEL_* constants.
- One sub-module, multicycle_ctrl_memwait: a timeout counter plus handshake hold, shared by FETCH and MEM.
- The FSM and output decode stay in the top module.

Test Plan:
- Reset, then dec_inst = INST_ADDU with mem_ready tied 1 -> states 0,1,2,4,0; reg_we = 1 with reg_dst = 1, wb_sel = 0 on cycle 4; ir_we/pc_we pulse on cycle 1.
- INST_LW with mem_ready delayed 3 cycles in MEM -> mem_req = 1, mem_sel = 1, mem_we = 0 held 4 cycles; WB has wb_sel = 1, reg_dst = 0; total 8 cycles.
- INST_BEQ with zero = 1, then zero = 0 -> pc_we with pc_src = 1 in EXEC only in the first case; both return to FETCH after 3 cycles.
- INST_JAL -> DECODE asserts pc_we, pc_src = 2, reg_we, reg_dst = 2, wb_sel = 2; next state FETCH.
- INST_ADDI with ovf = 1 -> WB has reg_we = 0; the next FETCH proceeds normally.
- INST_HLT -> halted = 1 and outputs stay quiet for 20 cycles; rst pulse mid-FETCH with mem_ready low -> mem_req drops during rst and FETCH restarts; with MEM_TIMEOUT = 4 and mem_ready stuck 0 -> mem_err = 1 and halted = 1 after 4 cycles.
